branch_predictor: RTL
=====================

# branch_predictor

Dynamic branch predictor for the fetch stage, directly upstream of the branch handler. Each cycle it looks up a table of 2-bit saturating counters, indexed by the fetch PC, and drives the `prediction` bit that travels down the pipe to the branch handler. When a branch resolves in EX, the block trains the indexed counter with the actual outcome. Optional saturating performance counters track resolved branches and mispredictions.

## Interface
Parameters:
- DBITS, 32, PC width in bits.
- INDEX_BITS, 4, log2 of table entries (default 16 entries).
- BRANCH_OPCODE, 4'b0010, EX opcode that identifies a conditional branch.

Ports:
- clk  input  1  sole clock, rising-edge.
- reset  input  1  asynchronous, active-high.
- fetch_pc  input  DBITS  PC of the instruction being fetched.
- prediction  output  1  1 = predict taken for fetch_pc.
- ex_valid  input  1  EX stage holds a valid instruction.
- ex_pc  input  DBITS  PC of the EX instruction.
- ex_opcode  input  4  opcode of the EX instruction.
- ex_cond_flag  input  1  actual branch outcome (1 = taken).
- ex_prediction  input  1  prediction that was carried with the EX instruction.
- stat_branches  output  32  resolved branch count (BP_STATS_EN only).
- stat_mispredicts  output  32  mispredicted branch count (BP_STATS_EN only).

## Operation
- Table: 2^INDEX_BITS entries, each a 2-bit counter.
  - 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken.
- Lookup index = fetch_pc[INDEX_BITS+1:2]. PCs are word-aligned, so bits [1:0] are ignored.
- prediction = table[lookup index][1], purely combinational.
- Update condition: ex_valid && ex_opcode == BRANCH_OPCODE.
  - Update index = ex_pc[INDEX_BITS+1:2].
  - ex_cond_flag = 1: counter increments, saturating at 11.
  - ex_cond_flag = 0: counter decrements, saturating at 00.
  - Non-branch opcodes and ex_valid = 0 leave the table untouched.
- Aliasing is permitted. PCs that differ only above bit INDEX_BITS+1 share an entry.
- At most one update per cycle; there is no write conflict case.

## Timing
- Reset (asynchronous, takes effect immediately):
  - Every counter is set to 01, so prediction reads 0 for any fetch_pc during and after reset.
  - Stat counters are set to 0.
- Lookup latency is 0 cycles: prediction follows fetch_pc combinationally.
- An update is written on the clk rising edge at the end of the cycle in which the update condition holds. It is visible to lookups from the next cycle.
- Same-cycle lookup and update of the same index:
  - The lookup returns the pre-update counter. There is no bypass.
  - The update is still applied at the edge.
- Reset asserted in the same cycle as an update: reset wins and the update is lost.
- Reset released: the table is usable on the first rising edge after deassertion.

## Configuration
- BP_STATS_EN defined:
  - On each update-condition cycle, stat_branches increments.
  - stat_mispredicts increments when ex_prediction != ex_cond_flag.
  - Both counters saturate at 32'hFFFFFFFF and never wrap.
  - Both reset to 0.
- BP_STATS_EN undefined:
  - The counters are not instantiated.
  - stat_branches and stat_mispredicts are tied to 32'd0.
  - Table behaviour is identical to the defined case.

## Test plan
- Reset: assert reset and sweep fetch_pc over 0x00..0x3C -> prediction = 0 at every address. With BP_STATS_EN, both stats read 0.
- Training to taken: two branch updates at ex_pc = 0x4 with ex_cond_flag = 1 -> counter goes 01→10→11. With fetch_pc = 0x4, prediction = 1 after the first edge and stays 1. A third taken update holds the counter at 11.
- Hysteresis: from 11 at ex_pc = 0x4, apply one not-taken update -> 10, prediction still 1. A second not-taken update -> 01, prediction = 0.
- Aliasing and filtering:
  - Update with ex_pc = 0x44 (same index as 0x4 for INDEX_BITS = 4) -> the fetch_pc = 0x4 prediction changes.
  - Update with ex_opcode = 4'b1100, or with ex_valid = 0 -> no counter changes.
- Same-cycle collision: fetch_pc = ex_pc = 0x8 with the counter at 01 and a taken update -> prediction = 0 in that cycle, 1 in the next.
- Stats (BP_STATS_EN): apply three branches with (ex_prediction, ex_cond_flag) = (1,1), (1,0), (0,1) -> stat_branches = 3, stat_mispredicts = 2. Preload near 32'hFFFFFFFF and apply further updates -> both counters saturate and do not wrap.

Source files
------------

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - 2-bit saturating-counter branch predictor indexed by fetch PC.
// Optional saturating branch/mispredict statistics when BP_STATS_EN is defined.
module branch_predictor #(
    parameter int         DBITS         = 32,
    parameter int         INDEX_BITS    = 4,
    parameter logic [3:0] BRANCH_OPCODE = 4'b0010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] fetch_pc,
    output logic             prediction,
    input  logic             ex_valid,
    input  logic [DBITS-1:0] ex_pc,
    input  logic [3:0]       ex_opcode,
    input  logic             ex_cond_flag,
    input  logic             ex_prediction,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            r_table [ENTRIES];
    logic [INDEX_BITS-1:0] w_lookup_idx;
    logic [INDEX_BITS-1:0] w_update_idx;
    logic                  w_update;
    logic                  w_unused;

    assign w_lookup_idx = fetch_pc[INDEX_BITS+1:2];
    assign w_update_idx = ex_pc[INDEX_BITS+1:2];
    assign w_update     = ex_valid && (ex_opcode == BRANCH_OPCODE);

    // No bypass: a same-cycle update to the looked-up entry is seen next cycle.
    assign prediction = r_table[w_lookup_idx][1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= 2'b01;
            end
        end else if (w_update) begin
            if (ex_cond_flag && (r_table[w_update_idx] != 2'b11)) begin
                r_table[w_update_idx] <= r_table[w_update_idx] + 2'b01;
            end else if (!ex_cond_flag && (r_table[w_update_idx] != 2'b00)) begin
                r_table[w_update_idx] <= r_table[w_update_idx] - 2'b01;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_branches    <= 32'd0;
            r_stat_mispredicts <= 32'd0;
        end else if (w_update) begin
            if (r_stat_branches != 32'hFFFF_FFFF) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if ((ex_prediction != ex_cond_flag) && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
    assign w_unused = ^{fetch_pc[DBITS-1:INDEX_BITS+2], fetch_pc[1:0],
                        ex_pc[DBITS-1:INDEX_BITS+2], ex_pc[1:0]};
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
    assign w_unused = ^{fetch_pc[DBITS-1:INDEX_BITS+2], fetch_pc[1:0],
                        ex_pc[DBITS-1:INDEX_BITS+2], ex_pc[1:0], ex_prediction};
`endif

endmodule
